seed_f_ctrl: RTL and testbench



---
 rtl/seed_f_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_seed_f_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seed_f_ctrl.sv
// -----------------------------------------------------------------------------
// seed_f_ctrl : sequencer for the SEED round function F.
//
// Takes one 64-bit half-block and one 64-bit round key through a valid/ready
// handshake. F is evaluated by time-sharing a single G-function datapath
// (SS0..SS3 XOR-combined) over three steps G1, G2 and G3.
//
// Ports:
//   i_Clk    in   1  clock, rising edge
//   i_Rst    in   1  synchronous active-high reset
//   i_Valid  in   1  request valid (accepted when i_Valid && o_Ready)
//   o_Ready  out  1  high only while idle
//   i_Data   in  64  half-block {R0, R1}
//   i_Key    in  64  round key  {K0, K1}
//   o_Valid  out  1  result valid, held until i_Ready
//   i_Ready  in   1  downstream accept
//   o_Data   out 64  F result {T0, T1}
//
// Build option:
//   SEED_G_PIPE_EN  registers the G output; each G step then spends one issue
//                   cycle and one capture cycle. Results are unchanged.
// -----------------------------------------------------------------------------
module seed_f_ctrl (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic [63:0] i_Data,
  input  logic [63:0] i_Key,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [63:0] o_Data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    G1   = 3'd1,
    G2   = 3'd2,
    G3   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] M0 = 8'hFC;
  localparam logic [7:0] M1 = 8'hF3;
  localparam logic [7:0] M2 = 8'hCF;
  localparam logic [7:0] M3 = 8'h3F;

  // GF(2^8) multiply, reduction polynomial x^8+x^6+x^5+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h63) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Left-to-right square-and-multiply power map.
  function automatic logic [7:0] gf_pow(input logic [7:0] x, input logic [7:0] e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] y, input int n);
    logic [15:0] w;
    w = {y, y} << n;
    return w[15:8];
  endfunction

  // S-boxes: power map followed by an affine transform.
  function automatic logic [7:0] sbox1(input logic [7:0] x);
    logic [7:0] y;
    y = gf_pow(x, 8'd247);
    return y ^ rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'hA9;
  endfunction

  function automatic logic [7:0] sbox2(input logic [7:0] x);
    logic [7:0] y;
    y = gf_pow(x, 8'd251);
    return y ^ rotl8(y, 2) ^ rotl8(y, 4) ^ rotl8(y, 7) ^ 8'h38;
  endfunction

  function automatic logic [31:0] ss0(input logic [7:0] x);
    logic [7:0] s;
    s = sbox1(x);
    return {s & M3, s & M2, s & M1, s & M0};
  endfunction

  function automatic logic [31:0] ss1(input logic [7:0] x);
    logic [7:0] s;
    s = sbox2(x);
    return {s & M0, s & M3, s & M2, s & M1};
  endfunction

  function automatic logic [31:0] ss2(input logic [7:0] x);
    logic [7:0] s;
    s = sbox1(x);
    return {s & M1, s & M0, s & M3, s & M2};
  endfunction

  function automatic logic [31:0] ss3(input logic [7:0] x);
    logic [7:0] s;
    s = sbox2(x);
    return {s & M2, s & M1, s & M0, s & M3};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] t0_q, t0_d;
  logic [31:0] t1_q, t1_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;

  logic [31:0] g_in;
  logic [31:0] g_out;
  logic [31:0] g_res;   // G value used by the register updates
  logic        cap;     // this cycle commits the current G step

  logic [31:0] r0k0;
  assign r0k0 = i_Data[63:32] ^ i_Key[63:32];

  // Single shared G datapath.
  assign g_out = ss3(g_in[31:24]) ^ ss2(g_in[23:16]) ^ ss1(g_in[15:8]) ^ ss0(g_in[7:0]);

`ifdef SEED_G_PIPE_EN
  logic [31:0] gpipe_q;
  logic        phase_q, phase_d;

  assign g_res = gpipe_q;
  assign cap   = phase_q;

  always_comb begin
    phase_d = phase_q;
    if (state_q == G1 || state_q == G2 || state_q == G3) phase_d = ~phase_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      gpipe_q <= 32'h0;
      phase_q <= 1'b0;
    end else begin
      gpipe_q <= g_out;
      phase_q <= phase_d;
    end
  end
`else
  assign g_res = g_out;
  assign cap   = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    data_d  = data_q;
    valid_d = valid_q;
    g_in    = t1_q;
    o_Ready = 1'b0;

    case (state_q)
      IDLE: begin
        o_Ready = 1'b1;
        if (i_Valid) begin
          t0_d    = r0k0;
          t1_d    = r0k0 ^ i_Data[31:0] ^ i_Key[31:0];
          state_d = G1;
        end
      end
      G1: begin
        g_in = t1_q;
        if (cap) begin
          t1_d    = g_res;
          state_d = G2;
        end
      end
      G2: begin
        g_in = t0_q + t1_q;
        if (cap) begin
          t0_d    = g_res;
          state_d = G3;
        end
      end
      G3: begin
        g_in = t1_q + t0_q;
        if (cap) begin
          t1_d    = g_res;
          data_d  = {t0_q + g_res, g_res};
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_Ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      t0_q    <= 32'h0;
      t1_q    <= 32'h0;
      data_q  <= 64'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_Valid = valid_q;
  assign o_Data  = data_q;

endmodule

// File: tb/tb_seed_f_ctrl.sv
module tb_seed_f_ctrl;

`ifdef SEED_G_PIPE_EN
  localparam int LAT      = 6;
  localparam int G2_TICKS = 2;
`else
  localparam int LAT      = 3;
  localparam int G2_TICKS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Valid;
  logic        o_Ready;
  logic [63:0] i_Data;
  logic [63:0] i_Key;
  logic        o_Valid;
  logic        i_Ready;
  logic [63:0] o_Data;

  always #5 clk = ~clk;

  seed_f_ctrl dut (
    .i_Clk  (clk),
    .i_Rst  (rst),
    .i_Valid(i_Valid),
    .o_Ready(o_Ready),
    .i_Data (i_Data),
    .i_Key  (i_Key),
    .o_Valid(o_Valid),
    .i_Ready(i_Ready),
    .o_Data (o_Data)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  s1_t[256];
  logic [7:0]  s2_t[256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h63) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] y, input int n);
    logic [7:0] r = y;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // x^247 = x^-8 and x^251 = x^-4 in GF(2^8)*, built from a brute-force inverse.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] p4, p8;
      for (int y = 1; y < 256; y++)
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      p4 = mul(mul(inv, inv), mul(inv, inv));
      p8 = mul(p4, p4);
      s1_t[x] = p8 ^ rl(p8, 1) ^ rl(p8, 3) ^ rl(p8, 6) ^ 8'hA9;
      s2_t[x] = p4 ^ rl(p4, 2) ^ rl(p4, 4) ^ rl(p4, 7) ^ 8'h38;
    end
  endtask

  function automatic logic [31:0] g_model(input logic [31:0] x);
    logic [7:0] a, b, c, d, z0, z1, z2, z3;
    a = s1_t[x[7:0]];
    b = s2_t[x[15:8]];
    c = s1_t[x[23:16]];
    d = s2_t[x[31:24]];
    z0 = (a & 8'hFC) ^ (b & 8'hF3) ^ (c & 8'hCF) ^ (d & 8'h3F);
    z1 = (a & 8'hF3) ^ (b & 8'hCF) ^ (c & 8'h3F) ^ (d & 8'hFC);
    z2 = (a & 8'hCF) ^ (b & 8'h3F) ^ (c & 8'hFC) ^ (d & 8'hF3);
    z3 = (a & 8'h3F) ^ (b & 8'hFC) ^ (c & 8'hF3) ^ (d & 8'hCF);
    return {z3, z2, z1, z0};
  endfunction

  function automatic logic [63:0] f_model(input logic [63:0] d, input logic [63:0] k);
    logic [31:0] t0, t1;
    t1 = g_model(d[63:32] ^ k[63:32] ^ d[31:0] ^ k[31:0]);
    t0 = g_model((d[63:32] ^ k[63:32]) + t1);
    t1 = g_model(t1 + t0);
    t0 = t0 + t1;
    return {t0, t1};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard push on accept, pop/compare on output handshake.
  task automatic tick(output bit acc, output bit hs);
    @(negedge clk);
    acc = i_Valid && o_Ready && !rst;
    hs  = o_Valid && i_Ready && !rst;
    if (rst) exp_q.delete();
    if (acc) exp_q.push_back(f_model(i_Data, i_Key));
    if (hs) begin
      if (exp_q.size() == 0) chk("spurious_valid", {63'd0, o_Valid}, 64'd0);
      else chk("o_Data", o_Data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [63:0] d, input logic [63:0] k,
                         input int stall, input bit check_lat);
    bit a, h;
    int n;
    i_Data  = d;
    i_Key   = k;
    i_Valid = 1'b1;
    i_Ready = (stall == 0);
    n = 0;
    do begin tick(a, h); n++; end while (!a && n < 20);
    if (!a) chk("accept_timeout", {63'd0, a}, 64'd1);
    i_Valid = 1'b0;
    n = 0;
    while (!o_Valid && n < 40) begin
      if (check_lat) chk("busy_ready", {63'd0, o_Ready}, 64'd0);
      tick(a, h);
      n++;
    end
    if (check_lat) chk("latency", 64'(n), 64'(LAT));
    for (int s = 0; s < stall; s++) begin
      tick(a, h);
      chk("stall_valid", {63'd0, o_Valid}, 64'd1);
      if (exp_q.size() != 0) chk("stall_data", o_Data, exp_q[0]);
      else chk("stall_queue", 64'(exp_q.size()), 64'd1);
    end
    i_Ready = 1'b1;
    n = 0;
    do begin tick(a, h); n++; end while (!h && n < 40);
    if (!h) chk("handshake_timeout", {63'd0, h}, 64'd1);
    chk("post_valid", {63'd0, o_Valid}, 64'd0);
    chk("post_ready", {63'd0, o_Ready}, 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit a, h;
    int n;
    logic [63:0] da, ka, db, kb;
    build_tables();
    rst = 1'b1; i_Valid = 1'b0; i_Ready = 1'b1; i_Data = '0; i_Key = '0;
    tick(a, h);
    tick(a, h);
    rst = 1'b0;
    chk("rst_ready", {63'd0, o_Ready}, 64'd1);
    chk("rst_valid", {63'd0, o_Valid}, 64'd0);
    chk("rst_data", o_Data, 64'd0);

    // zero block / zero key with latency and busy checks
    run_job(64'd0, 64'd0, 0, 1'b1);

    // modulo-2^32 wrap cases
    run_job({32'hFFFFFFFF, 32'h00000000}, 64'd0, 0, 1'b1);
    run_job({32'hFFFFFFFF, 32'h12345678}, {32'h00000000, 32'h9ABCDEF0}, 0, 1'b0);
    run_job(64'hFFFFFFFF_FFFFFFFF, 64'h80000000_7FFFFFFF, 0, 1'b0);

    // backpressure: 10 stalled cycles then a single-cycle release
    run_job(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 10, 1'b1);

    // request held high with new data while busy
    da = 64'hDEADBEEF_CAFEF00D; ka = 64'h11111111_22222222;
    db = 64'h0BADC0DE_13579BDF; kb = 64'h33333333_44444444;
    i_Data = da; i_Key = ka; i_Valid = 1'b1; i_Ready = 1'b1;
    n = 0;
    do begin tick(a, h); n++; end while (!a && n < 20);
    i_Data = db; i_Key = kb;
    n = 0;
    do begin
      chk("held_ready", {63'd0, o_Ready}, 64'd0);
      tick(a, h);
      chk("held_no_accept", {63'd0, a}, 64'd0);
      n++;
    end while (!h && n < 40);
    chk("held_ready_back", {63'd0, o_Ready}, 64'd1);
    tick(a, h);
    chk("held_accept", {63'd0, a}, 64'd1);
    i_Valid = 1'b0;
    n = 0;
    do begin tick(a, h); n++; end while (!h && n < 40);
    chk("held_second_done", {63'd0, h}, 64'd1);
    chk("held_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset in G2 aborts the job
    i_Data = 64'hA5A5A5A5_5A5A5A5A; i_Key = 64'h0F0F0F0F_F0F0F0F0; i_Valid = 1'b1;
    n = 0;
    do begin tick(a, h); n++; end while (!a && n < 20);
    i_Valid = 1'b0;
    for (int i = 0; i < G2_TICKS; i++) tick(a, h);
    rst = 1'b1;
    tick(a, h);
    rst = 1'b0;
    chk("abort_ready", {63'd0, o_Ready}, 64'd1);
    chk("abort_valid", {63'd0, o_Valid}, 64'd0);
    chk("abort_data", o_Data, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick(a, h);
      chk("abort_no_valid", {63'd0, o_Valid}, 64'd0);
    end
    run_job(64'hA5A5A5A5_5A5A5A5A, 64'h0F0F0F0F_F0F0F0F0, 0, 1'b1);

    // random traffic
    for (int i = 0; i < 1000; i++)
      run_job({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
